// File: rtl/uart_byte_rx_if.sv
// Byte-level connection between the serial receiver and the line/consumer side.
// The receiver uses the slave view; the bench or upstream logic uses the master view.
interface uart_byte_rx_if;
    logic       RX;
    logic [7:0] data;
    logic       dataAvail;
    logic       RXvalid;
    logic       RXerror;

    modport master (
        output RX,
        input  data, dataAvail, RXvalid, RXerror
    );

    modport slave (
        input  RX,
        output data, dataAvail, RXvalid, RXerror
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver with false-start rejection and framing-error/break handling.
// Each good byte updates data, toggles dataAvail and pulses RXvalid in the same cycle.
module uart_byte_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic          CLOCK,
    input  logic          reset,
    uart_byte_rx_if.slave rx_if
);

    localparam int unsigned     CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             avail_q, avail_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        sync_d    = {sync_q[0], rx_if.RX};
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        avail_d   = avail_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a start edge right after the stop bit is caught.
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        avail_d = ~avail_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            avail_q   <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            avail_q   <= avail_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.dataAvail = avail_q;
    assign rx_if.RXvalid   = valid_q;
    assign rx_if.RXerror   = error_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed frame table, hand-written corner
// sequences and random frames compared against a byte-queue model of the line.
module tb_uart_byte_rx;

    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    int   cyc;

    uart_byte_rx_if ifc ();

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK (clk),
        .reset (rst_n),
        .rx_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_pass;

    // Observed activity, sampled on the falling edge.
    int         n_valid, n_err, n_toggle, n_proto;
    int         valid_cyc;
    logic [7:0] got_q[$];
    logic       last_avail;
    logic [7:0] last_data;
    int         start_cyc;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_avail = ifc.dataAvail;
            last_data  = ifc.data;
        end else begin
            if (ifc.RXvalid) begin
                n_valid++;
                got_q.push_back(ifc.data);
                valid_cyc = cyc;
            end
            if (ifc.RXerror) n_err++;
            if (ifc.dataAvail != last_avail) n_toggle++;
            if ((ifc.dataAvail != last_avail) != ifc.RXvalid) n_proto++;
            if ((ifc.data != last_data) && !ifc.RXvalid) n_proto++;
            if (ifc.RXvalid && ifc.RXerror) n_proto++;
            last_avail = ifc.dataAvail;
            last_data  = ifc.data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic drive_bit(input logic b);
        ifc.RX = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        ifc.RX = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] payload;
        int         gap_bits;
        logic [7:0] exp_data;
        logic       exp_avail;
        int         exp_valid;
        logic       chk_lat;
    } vec_t;

    vec_t vecs[4];

    int v0, e0, t0, bad, base, exp_err;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       stp;
    int         gap, act, lat;

    initial begin
        n_checks = 0; n_pass = 0;
        n_valid = 0; n_err = 0; n_toggle = 0; n_proto = 0; valid_cyc = 0; cyc = 0;
        vecs[0] = '{8'hA5, 2, 8'hA5, 1'b1, 1, 1'b1};
        vecs[1] = '{8'h3F, 0, 8'h3F, 1'b0, 1, 1'b0};
        vecs[2] = '{8'h01, 2, 8'h01, 1'b1, 1, 1'b0};
        vecs[3] = '{8'h55, 2, 8'h55, 1'b0, 1, 1'b0};

        // Reset held with a toggling line: outputs must stay at reset values.
        rst_n  = 1'b0;
        ifc.RX = 1'b1;
        bad    = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ifc.RX = ~ifc.RX;
            if (ifc.data !== 8'h00 || ifc.dataAvail !== 1'b0 ||
                ifc.RXvalid !== 1'b0 || ifc.RXerror !== 1'b0) bad++;
        end
        check("reset_hold_outputs", bad, 0);

        ifc.RX = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid; e0 = n_err; t0 = n_toggle;
        repeat (100) @(negedge clk);
        #1;
        check("post_reset_data", ifc.data, 8'h00);
        check("post_reset_avail", ifc.dataAvail, 0);
        check("post_reset_activity", (n_valid - v0) + (n_err - e0) + (n_toggle - t0), 0);

        // Directed frame table; entries 1 and 2 are back-to-back.
        for (int i = 0; i < 4; i++) begin
            v0 = n_valid; e0 = n_err;
            send_frame(vecs[i].payload, 1'b1);
            #1;
            check($sformatf("vec%0d_data", i), ifc.data, vecs[i].exp_data);
            check($sformatf("vec%0d_avail", i), ifc.dataAvail, vecs[i].exp_avail);
            check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), n_err - e0, 0);
            if (vecs[i].chk_lat) begin
                lat = valid_cyc - start_cyc;
                check("vec_latency_in_window", int'(lat >= 150 && lat <= 160), 1);
            end
            if (i == 2) check("assembled_pos", {got_q[got_q.size()-1], got_q[got_q.size()-2]}, 319);
            if (vecs[i].gap_bits > 0) idle_bits(vecs[i].gap_bits);
        end

        // Short low pulse must be rejected as a false start.
        v0 = n_valid; e0 = n_err; t0 = n_toggle;
        ifc.RX = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        check("glitch_activity", (n_valid - v0) + (n_err - e0) + (n_toggle - t0), 0);
        v0 = n_valid;
        send_frame(8'h55, 1'b1);
        idle_bits(1);
        check("after_glitch_data", ifc.data, 8'h55);
        check("after_glitch_valid", n_valid - v0, 1);

        // Framing error followed by a long break.
        v0 = n_valid; e0 = n_err; t0 = n_toggle;
        send_frame(8'h7E, 1'b0);
        ifc.RX = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        check("frame_err_count", n_err - e0, 1);
        check("frame_err_valid", n_valid - v0, 0);
        check("frame_err_data_held", ifc.data, 8'h55);
        check("frame_err_no_toggle", n_toggle - t0, 0);
        idle_bits(2);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h12, 1'b1);
        idle_bits(1);
        check("after_break_data", ifc.data, 8'h12);
        check("after_break_valid", n_valid - v0, 1);
        check("after_break_err", n_err - e0, 0);

        // Reset in the middle of 0xFF, after four data bits.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_data", ifc.data, 8'h00);
        check("midreset_avail", ifc.dataAvail, 0);
        check("midreset_pulses", int'(ifc.RXvalid) + int'(ifc.RXerror), 0);
        repeat (5) @(negedge clk);
        ifc.RX = 1'b1;
        rst_n  = 1'b1;
        idle_bits(3);
        v0 = n_valid; t0 = n_toggle; e0 = n_err;
        send_frame(8'h80, 1'b1);
        idle_bits(1);
        check("after_midreset_data", ifc.data, 8'h80);
        check("after_midreset_toggles", n_toggle - t0, 1);
        check("after_midreset_avail", ifc.dataAvail, 1);
        check("after_midreset_err", n_err - e0, 0);

        // Random frames against a byte-queue model.
        base = got_q.size(); v0 = n_valid; e0 = n_err; exp_err = 0;
        for (int i = 0; i < 30; i++) begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            gap = stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(b, stp);
            if (stp) exp_q.push_back(b);
            else exp_err++;
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(2);
        check("rand_valid_count", n_valid - v0, exp_q.size());
        check("rand_err_count", n_err - e0, exp_err);
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (base + i < got_q.size()) ? int'(got_q[base + i]) : -1;
            check($sformatf("rand_byte%0d", i), act, exp_q[i]);
        end

        check("protocol_violations", n_proto, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
